// File: rtl/ft_pkg.sv
// Shared fault-tolerance types: recovery FSM states and the GPR sweep range.
package ft_pkg;

  typedef enum logic [2:0] {IDLE, HALT, COPY, DRAIN, RESUME} recov_state_e;

  localparam int GPR_FIRST = 1;
  localparam int GPR_LAST  = 31;

endpackage

// File: rtl/sgpr_recovery_if.sv
// Comparator / core / shadow-RF side of the SGPR recovery block, plus FSM state for observation.
interface sgpr_recovery_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 8
);
  import ft_pkg::*;

  // Level signals only, no valid/ready: error_i is sampled in IDLE, halted_i in HALT,
  // and shadow_rdata_i answers shadow_addr_o one cycle later.
  logic                  error_i;
  logic                  halt_o;
  logic                  halted_i;
  logic [ADDR_WIDTH-1:0] shadow_addr_o;
  logic [DATA_WIDTH-1:0] shadow_rdata_i;
  logic                  we_o;
  logic [ADDR_WIDTH-1:0] waddr_o;
  logic [DATA_WIDTH-1:0] wdata_o;
  logic                  busy_o;
  logic                  done_o;
  logic [CNT_WIDTH-1:0]  recov_cnt_o;
  recov_state_e          state;

  modport master (
    input  error_i, halted_i, shadow_rdata_i,
    output halt_o, shadow_addr_o, we_o, waddr_o, wdata_o, busy_o, done_o, recov_cnt_o, state
  );

  modport slave (
    output error_i, halted_i, shadow_rdata_i,
    input  halt_o, shadow_addr_o, we_o, waddr_o, wdata_o, busy_o, done_o, recov_cnt_o, state
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sgpr_recovery.sv
// Halts both cores on a write mismatch and rewrites x1..x31 from the shadow RF.
// Optional recovery counter enabled with `define SGPR_RECOVERY_CNT_EN.
module sgpr_recovery
  import ft_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  sgpr_recovery_if.master      bus
);

  localparam logic [ADDR_WIDTH-1:0] FIRST = ADDR_WIDTH'(GPR_FIRST);
  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(NUM_REGS - 1);

  recov_state_e          state;
  logic [ADDR_WIDTH-1:0] rp;
  logic [ADDR_WIDTH-1:0] rp_d;
  logic                  rd_v;
  logic                  wr_v;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  we;
  logic                  done;

  // rd_v/wr_v mark the read and write stages of the COPY pipeline; the write of LAST ends it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      rp      <= '0;
      rp_d    <= '0;
      rd_v    <= 1'b0;
      wr_v    <= 1'b0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.error_i) state <= HALT;
        HALT: if (bus.halted_i) begin
          state <= COPY;
          rp    <= FIRST;
          rd_v  <= 1'b1;
          wr_v  <= 1'b0;
        end
        COPY: begin
          rp_d <= rp;
          wr_v <= rd_v;
          if (rp == LAST) rd_v <= 1'b0;
          else            rp   <= rp + 1'b1;
          if (wr_v) wdata_q <= bus.shadow_rdata_i;
          if (wr_v && (rp_d == LAST)) state <= DRAIN;
        end
        DRAIN:   state <= RESUME;
        RESUME:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign we   = (state == COPY) && wr_v;
  assign done = (state == RESUME);

  // waddr needs no hold register: rp_d only moves in COPY and keeps the last written address.
  assign bus.state         = state;
  assign bus.halt_o        = (state == HALT) || (state == COPY) || (state == DRAIN);
  assign bus.busy_o        = (state != IDLE);
  assign bus.done_o        = done;
  assign bus.we_o          = we;
  assign bus.shadow_addr_o = rp;
  assign bus.waddr_o       = rp_d;
  assign bus.wdata_o       = we ? bus.shadow_rdata_i : wdata_q;

`ifdef SGPR_RECOVERY_CNT_EN
  logic [CNT_WIDTH-1:0] cnt;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .inc   (done),
    .count (cnt)
  );

  assign bus.recov_cnt_o = cnt;
`else
  assign bus.recov_cnt_o = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_sgpr_recovery.sv
// Randomized scoreboard bench for sgpr_recovery: expected GPR writes queued per recovery.
module tb_sgpr_recovery;
  import ft_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;
  localparam int CW = 2;
`ifdef SGPR_RECOVERY_CNT_EN
  localparam int CNT_MAX = (1 << CW) - 1;
`else
  localparam int CNT_MAX = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sgpr_recovery_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  sgpr_recovery #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .CNT_WIDTH(CW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // Shadow register file: registered read, one cycle latency.
  logic [DW-1:0] shadow [NR];
  always @(posedge clk) bus.shadow_rdata_i <= shadow[bus.shadow_addr_o];

  // ---------------- scoreboard ----------------
  logic [AW+DW-1:0] exp_q[$];
  int exp_done = 0;
  int n_rec    = 0;
  int n_cmp    = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic             done_prev = 1'b0;
  logic [AW+DW-1:0] e;
  int               exp_cnt;
  always @(negedge clk) begin
    if (!rst_n) begin
      n_rec     = 0;
      done_prev = 1'b0;
    end else begin
      if (done_prev) begin
        n_rec++;
        exp_cnt = (n_rec > CNT_MAX) ? CNT_MAX : n_rec;
        check("recov_cnt", 64'(bus.recov_cnt_o), 64'(exp_cnt));
      end
      if (bus.we_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(bus.waddr_o), 64'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check("waddr", 64'(bus.waddr_o), 64'(e[AW+DW-1:DW]));
          check("wdata", 64'(bus.wdata_o), 64'(e[DW-1:0]));
        end
      end
      if (bus.done_o) begin
        check("done_expected", 64'(exp_done > 0), 64'd1);
        check("writes_left_at_done", 64'(exp_q.size()), 64'd0);
        if (exp_done > 0) exp_done--;
      end
      done_prev = bus.done_o;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check("idle_busy", 64'(bus.busy_o), 64'd0);
      check("idle_halt", 64'(bus.halt_o), 64'd0);
    end
  endtask

  // One recovery: error asserted now, halted_i sampled h edges later.
  task automatic recover(input int h, input bit rand_data, input bit noisy,
                         input bit err_at_done, input int abort_at);
    int steps;
    int first_we;
    bit seen_done;
    for (int i = 1; i < NR; i++) begin
      shadow[i] = rand_data ? $urandom : (32'hA5A5_0000 + 32'(i));
      exp_q.push_back({AW'(i), shadow[i]});
    end
    exp_done++;
    bus.error_i  = 1'b1;
    bus.halted_i = 1'b0;
    step();
    check("halt_after_error", 64'(bus.halt_o), 64'd1);
    check("busy_after_error", 64'(bus.busy_o), 64'd1);
    bus.error_i = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    for (int j = 1; j < h; j++) begin
      step();
      check("halt_waiting", 64'(bus.halt_o), 64'd1);
      check("we_while_halting", 64'(bus.we_o), 64'd0);
      if (noisy) bus.error_i = 1'($urandom_range(0, 1));
    end
    bus.halted_i = 1'b1;
    step();
    steps = 0;
    first_we = -1;
    seen_done = 1'b0;
    while (!seen_done && steps < 100) begin
      if (bus.we_o && first_we < 0) first_we = steps;
      if (abort_at != 0 && bus.we_o && int'(bus.waddr_o) == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_we", 64'(bus.we_o), 64'd0);
        check("abort_halt", 64'(bus.halt_o), 64'd0);
        check("abort_busy", 64'(bus.busy_o), 64'd0);
        check("abort_waddr", 64'(bus.waddr_o), 64'd0);
        check("abort_wdata", 64'(bus.wdata_o), 64'd0);
        check("abort_state", 64'(bus.state), 64'(IDLE));
        exp_q.delete();
        exp_done--;
        bus.error_i  = 1'b0;
        bus.halted_i = 1'b0;
        step();
        rst_n = 1'b1;
        return;
      end
      if (bus.done_o) begin
        seen_done = 1'b1;
      end else begin
        check("busy_in_sweep", 64'(bus.busy_o), 64'd1);
        if (noisy) begin
          bus.error_i  = 1'($urandom_range(0, 1));
          bus.halted_i = 1'($urandom_range(0, 1));
        end
        step();
        steps++;
      end
    end
    if (!seen_done) begin
      check("done_timeout", 64'd0, 64'd1);
    end else begin
      check("first_write_latency", 64'(first_we), 64'd1);
      check("sweep_length", 64'(steps), 64'd33);
      check("resume_halt", 64'(bus.halt_o), 64'd0);
      check("resume_busy", 64'(bus.busy_o), 64'd1);
    end
    bus.error_i  = err_at_done;
    bus.halted_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < NR; i++) shadow[i] = '0;
    rst_n        = 1'b0;
    bus.error_i  = 1'b1;
    bus.halted_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_halt", 64'(bus.halt_o), 64'd0);
    check("rst_we", 64'(bus.we_o), 64'd0);
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_done", 64'(bus.done_o), 64'd0);
    check("rst_shadow_addr", 64'(bus.shadow_addr_o), 64'd0);
    check("rst_waddr", 64'(bus.waddr_o), 64'd0);
    check("rst_wdata", 64'(bus.wdata_o), 64'd0);
    check("rst_cnt", 64'(bus.recov_cnt_o), 64'd0);
    rst_n = 1'b1;

    recover(3, 1'b0, 1'b0, 1'b0, 0);
    idle_cycles(2);
    recover($urandom_range(1, 5), 1'b1, 1'b1, 1'b0, 0);
    idle_cycles(5);
    recover($urandom_range(1, 5), 1'b1, 1'b0, 1'b1, 0);
    idle_cycles(1);
    recover($urandom_range(1, 5), 1'b1, 1'b0, 1'b0, 0);
    idle_cycles(1);
    recover($urandom_range(1, 5), 1'b1, 1'b1, 1'b0, 0);
    idle_cycles(3);

    recover(2, 1'b1, 1'b0, 1'b0, 10);
    check("after_abort_cnt", 64'(bus.recov_cnt_o), 64'd0);
    recover(2, 1'b0, 1'b0, 1'b0, 0);
    idle_cycles(2);

    // Cores never acknowledge: halt must stay up with no writes and no done.
    bus.error_i = 1'b1;
    step();
    bus.error_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      check("stuck_halt", 64'(bus.halt_o), 64'd1);
      check("stuck_we", 64'(bus.we_o), 64'd0);
      check("stuck_done", 64'(bus.done_o), 64'd0);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle_cycles(2);

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    check("exp_done_zero", 64'(exp_done), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
